// File: rtl/fifo_tx_packer.sv
// ============================================================================
// Module      : fifo_tx_packer
// Description : Pulls bytes from an 8-bit FIFO read port (one-cycle read
//               latency) and emits them as sof/eof framed bursts with
//               valid/ready handshake. A full frame of PAYLOAD_LEN bytes
//               starts on FIFO almost-full; a shorter flush frame starts once
//               the FIFO has been non-empty without almost-full for TIMEOUT
//               cycles.
//               Optional feature macro: FIFO_TX_PACKER_STATS_EN adds the
//               frame_cnt / flush_cnt statistics outputs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_tx_packer #(
   parameter int PAYLOAD_LEN = 64,
   parameter int TIMEOUT     = 256
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  fifo_do,
   input  logic        fifo_empty,
   input  logic        fifo_afull,
   output logic        fifo_re,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   output logic        tx_sof,
   output logic        tx_eof,
   input  logic        tx_ready,
   output logic        busy
`ifdef FIFO_TX_PACKER_STATS_EN
   ,
   output logic [15:0] frame_cnt,
   output logic [15:0] flush_cnt
`endif
);

   localparam int              TMR_W    = $clog2(TIMEOUT);
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
   localparam logic [15:0]     LEN16    = 16'(PAYLOAD_LEN);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ARM    = 2'd1,
      S_STREAM = 2'd2,
      S_DRAIN  = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic             flush_mode_q, flush_mode_d;   // 1: current frame is a timeout flush
   logic [TMR_W-1:0] timer_q, timer_d;
   logic [15:0]      rd_cnt_q, rd_cnt_d;
   logic             inflight_q, inflight_d;       // a read issued last cycle lands now
   logic [7:0]       skid0_q, skid0_d;             // head of the skid buffer
   logic [7:0]       skid1_q, skid1_d;
   logic [1:0]       occ_q, occ_d;                 // skid occupancy, 0..2
   logic             first_q, first_d;             // next byte out is the frame's first

   logic             w_pop;
   logic             w_end;
   logic             w_end_known;
   logic [1:0]       w_occ_after;

   // End of reads: payload cap reached, or (flush) FIFO drained with nothing in flight.
   assign w_end       = (state_q == S_STREAM) &&
                        ((rd_cnt_q == LEN16) || (flush_mode_q && fifo_empty && !inflight_q));
   assign w_end_known = (state_q == S_DRAIN) || w_end;

   // A flush frame holds its head byte until a successor is buffered or the end is
   // known, so eof can be attached to the right byte without retracting a byte.
   assign tx_valid = (occ_q != 2'd0) && (!flush_mode_q || (occ_q == 2'd2) || w_end_known);
   assign tx_sof   = tx_valid && first_q;
   assign tx_eof   = tx_valid && w_end_known && (occ_q == 2'd1) && !inflight_q;
   assign tx_data  = skid0_q;
   assign busy     = (state_q != S_IDLE);

   assign w_pop       = tx_valid && tx_ready;
   // Occupancy after this cycle's departure lets reads keep pace at one byte per cycle.
   assign w_occ_after = occ_q - {1'b0, w_pop};
   assign fifo_re     = (state_q == S_STREAM) && !fifo_empty && (rd_cnt_q < LEN16) &&
                        ((w_occ_after + {1'b0, inflight_q}) < 2'd2);

   // Next-state, counters, and skid buffer update.
   always_comb begin
      state_d      = state_q;
      flush_mode_d = flush_mode_q;
      timer_d      = timer_q;
      rd_cnt_d     = rd_cnt_q;
      first_d      = first_q;
      skid0_d      = skid0_q;
      skid1_d      = skid1_q;
      occ_d        = occ_q;
      inflight_d   = fifo_re;

      if (fifo_re) begin
         rd_cnt_d = rd_cnt_q + 16'd1;
      end
      if (w_pop) begin
         first_d = 1'b0;
      end

      case (state_q)
         S_IDLE: begin
            if (!fifo_empty) begin
               state_d = S_ARM;
               timer_d = '0;
            end
         end
         S_ARM: begin
            if (fifo_afull || (timer_q == TMR_LAST)) begin
               state_d      = S_STREAM;
               flush_mode_d = !fifo_afull;
               rd_cnt_d     = 16'd0;
               first_d      = 1'b1;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         S_STREAM: begin
            if (w_end) begin
               state_d = (w_pop && tx_eof) ? S_IDLE : S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (w_pop && tx_eof) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      case ({inflight_q, w_pop})
         2'b01: begin
            skid0_d = skid1_q;
            occ_d   = occ_q - 2'd1;
         end
         2'b10: begin
            if (occ_q == 2'd0) begin
               skid0_d = fifo_do;
            end else begin
               skid1_d = fifo_do;
            end
            occ_d = occ_q + 2'd1;
         end
         2'b11: begin
            if (occ_q == 2'd1) begin
               skid0_d = fifo_do;
            end else begin
               skid0_d = skid1_q;
               skid1_d = fifo_do;
            end
         end
         default: ;
      endcase
   end

   // State and datapath registers; reset discards any buffered byte.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         flush_mode_q <= 1'b0;
         timer_q      <= '0;
         rd_cnt_q     <= 16'd0;
         inflight_q   <= 1'b0;
         skid0_q      <= 8'd0;
         skid1_q      <= 8'd0;
         occ_q        <= 2'd0;
         first_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         flush_mode_q <= flush_mode_d;
         timer_q      <= timer_d;
         rd_cnt_q     <= rd_cnt_d;
         inflight_q   <= inflight_d;
         skid0_q      <= skid0_d;
         skid1_q      <= skid1_d;
         occ_q        <= occ_d;
         first_q      <= first_d;
      end
   end

`ifdef FIFO_TX_PACKER_STATS_EN
   logic [15:0] frame_cnt_q, frame_cnt_d;
   logic [15:0] flush_cnt_q, flush_cnt_d;

   // Count accepted eof bytes; flush frames counted separately. Both wrap.
   always_comb begin
      frame_cnt_d = frame_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (w_pop && tx_eof) begin
         frame_cnt_d = frame_cnt_q + 16'd1;
         if (flush_mode_q) begin
            flush_cnt_d = flush_cnt_q + 16'd1;
         end
      end
   end

   // Statistics registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frame_cnt_q <= 16'd0;
         flush_cnt_q <= 16'd0;
      end else begin
         frame_cnt_q <= frame_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign frame_cnt = frame_cnt_q;
   assign flush_cnt = flush_cnt_q;
`endif

endmodule

`default_nettype wire
